// File: rtl/recfg_array_pkg.sv
// Shared mode encoding, default sizes and mode-class helpers for the reconfigurable tile array.
package recfg_array_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TILE_SIZE  = 16;

    typedef enum logic [2:0] {
        MODE_GEMV    = 3'b000,
        MODE_EWM_VEC = 3'b001,
        MODE_EWA_VEC = 3'b100,
        MODE_EWA_MAT = 3'b101,
        MODE_EWM_MAT = 3'b110
    } mode_e;

    function automatic logic is_mat_mode(input logic [2:0] m);
        return (m == MODE_EWA_MAT) || (m == MODE_EWM_MAT);
    endfunction

    function automatic logic is_vec_mode(input logic [2:0] m);
        return (m == MODE_GEMV) || (m == MODE_EWM_VEC) || (m == MODE_EWA_VEC);
    endfunction

    function automatic logic is_add_mode(input logic [2:0] m);
        return (m == MODE_EWA_VEC) || (m == MODE_EWA_MAT);
    endfunction

endpackage

// File: rtl/recfg_array_pe.sv
// Processing element: one signed multiply-or-add at full (2*DATA_WIDTH) precision.
module recfg_pe #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0]   i_a,
    input  logic signed [DATA_WIDTH-1:0]   i_b,
    input  logic                           i_add,
    output logic signed [2*DATA_WIDTH-1:0] o_res
);

    localparam int PW = 2 * DATA_WIDTH;

    always_comb begin
        o_res = i_add ? (PW'(i_a) + PW'(i_b)) : (PW'(i_a) * PW'(i_b));
    end

endmodule

// File: rtl/recfg_array.sv
// Reconfigurable T x T tile engine: GEMV and element-wise vector/matrix ops, 2-cycle pipeline.
module recfg_array
    import recfg_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TILE_SIZE  = DEF_TILE_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic [2:0]                   mode,
    input  logic signed [DATA_WIDTH-1:0] a_in           [TILE_SIZE][TILE_SIZE],
    input  logic signed [DATA_WIDTH-1:0] b_vec          [TILE_SIZE],
    input  logic signed [DATA_WIDTH-1:0] b_mat          [TILE_SIZE][TILE_SIZE],
    input  logic                         accumulate_en,
    input  logic signed [DATA_WIDTH-1:0] acc_in_vec     [TILE_SIZE],
    output logic signed [DATA_WIDTH-1:0] result_out_vec [TILE_SIZE],
    output logic signed [DATA_WIDTH-1:0] result_out_mat [TILE_SIZE][TILE_SIZE],
    output logic                         valid_out,
    output logic                         done_tile,
    output logic                         out_shape_flag
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = PW + $clog2(TILE_SIZE) + 1;

    logic                         w_add;
    logic signed [DATA_WIDTH-1:0] w_pe_b   [TILE_SIZE][TILE_SIZE];
    logic signed [PW-1:0]         w_pe_res [TILE_SIZE][TILE_SIZE];
    logic signed [SW-1:0]         w_tree   [TILE_SIZE][TILE_SIZE];
    logic signed [SW-1:0]         w_sum    [TILE_SIZE];
    logic signed [DATA_WIDTH-1:0] w_s2_vec [TILE_SIZE];

    logic                         r_s1_valid;
    logic [2:0]                   r_s1_mode;
    logic                         r_s1_acc_en;
    logic signed [DATA_WIDTH-1:0] r_s1_acc [TILE_SIZE];
    logic signed [PW-1:0]         r_s1_pe  [TILE_SIZE][TILE_SIZE];

    logic                         r_s2_valid;
    logic                         r_s2_is_mat;
    logic signed [DATA_WIDTH-1:0] r_s2_vec [TILE_SIZE];
    logic signed [DATA_WIDTH-1:0] r_s2_mat [TILE_SIZE][TILE_SIZE];

    logic                         r_valid_out;
    logic                         r_shape;
    logic signed [DATA_WIDTH-1:0] r_out_vec [TILE_SIZE];
    logic signed [DATA_WIDTH-1:0] r_out_mat [TILE_SIZE][TILE_SIZE];

    // Element-wise vector modes use column 0 of each row, paired with b_vec[row].
    always_comb begin
        w_add = is_add_mode(mode);
        for (int i = 0; i < TILE_SIZE; i++) begin
            for (int j = 0; j < TILE_SIZE; j++) begin
                if (is_mat_mode(mode)) begin
                    w_pe_b[i][j] = b_mat[i][j];
                end else if ((mode != MODE_GEMV) && (j == 0)) begin
                    w_pe_b[i][j] = b_vec[i];
                end else begin
                    w_pe_b[i][j] = b_vec[j];
                end
            end
        end
    end

    for (genvar gi = 0; gi < TILE_SIZE; gi++) begin : g_row
        for (genvar gj = 0; gj < TILE_SIZE; gj++) begin : g_col
            recfg_pe #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_pe (
                .i_a   (a_in[gi][gj]),
                .i_b   (w_pe_b[gi][gj]),
                .i_add (w_add),
                .o_res (w_pe_res[gi][gj])
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_acc_en <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                r_s1_acc[i] <= '0;
                for (int j = 0; j < TILE_SIZE; j++) r_s1_pe[i][j] <= '0;
            end
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_s1_mode   <= mode;
                r_s1_acc_en <= accumulate_en;
                for (int i = 0; i < TILE_SIZE; i++) begin
                    r_s1_acc[i] <= acc_in_vec[i];
                    for (int j = 0; j < TILE_SIZE; j++) r_s1_pe[i][j] <= w_pe_res[i][j];
                end
            end
        end
    end

    // Pairwise in-place reduction per row; the row total ends up in element 0.
    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            for (int j = 0; j < TILE_SIZE; j++) w_tree[i][j] = SW'(r_s1_pe[i][j]);
            for (int s = 1; s < TILE_SIZE; s = s * 2) begin
                for (int k = 0; k + s < TILE_SIZE; k = k + 2 * s) begin
                    w_tree[i][k] = w_tree[i][k] + w_tree[i][k+s];
                end
            end
            case (r_s1_mode)
                MODE_GEMV:                  w_sum[i] = w_tree[i][0];
                MODE_EWM_VEC, MODE_EWA_VEC: w_sum[i] = SW'(r_s1_pe[i][0]);
                default:                    w_sum[i] = '0;
            endcase
            if (r_s1_acc_en && is_vec_mode(r_s1_mode)) begin
                w_sum[i] = w_sum[i] + SW'(r_s1_acc[i]);
            end
            w_s2_vec[i] = w_sum[i][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_is_mat <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                r_s2_vec[i] <= '0;
                for (int j = 0; j < TILE_SIZE; j++) r_s2_mat[i][j] <= '0;
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_is_mat <= is_mat_mode(r_s1_mode);
                for (int i = 0; i < TILE_SIZE; i++) begin
                    r_s2_vec[i] <= w_s2_vec[i];
                    for (int j = 0; j < TILE_SIZE; j++) begin
                        r_s2_mat[i][j] <= r_s1_pe[i][j][DATA_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Only the shape produced by a transaction is refreshed; the other holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out <= 1'b0;
            r_shape     <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                r_out_vec[i] <= '0;
                for (int j = 0; j < TILE_SIZE; j++) r_out_mat[i][j] <= '0;
            end
        end else begin
            r_valid_out <= r_s2_valid;
            if (r_s2_valid) begin
                r_shape <= r_s2_is_mat;
                if (r_s2_is_mat) begin
                    for (int i = 0; i < TILE_SIZE; i++) begin
                        for (int j = 0; j < TILE_SIZE; j++) r_out_mat[i][j] <= r_s2_mat[i][j];
                    end
                end else begin
                    for (int i = 0; i < TILE_SIZE; i++) r_out_vec[i] <= r_s2_vec[i];
                end
            end
        end
    end

    assign valid_out      = r_valid_out;
    assign done_tile      = r_valid_out;
    assign out_shape_flag = r_shape;
    assign result_out_vec = r_out_vec;
    assign result_out_mat = r_out_mat;

endmodule

// File: tb/tb_recfg_array.sv
// Directed table-driven bench for recfg_array with hand-computed expected results.
module tb_recfg_array;
    import recfg_array_pkg::*;

    localparam int DW = 16;
    localparam int T  = 16;
    localparam int NV = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic accumulate_en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic signed [DW-1:0] a_in [T][T];
    logic signed [DW-1:0] b_vec [T];
    logic signed [DW-1:0] b_mat [T][T];
    logic signed [DW-1:0] acc_in_vec [T];
    logic signed [DW-1:0] result_out_vec [T];
    logic signed [DW-1:0] result_out_mat [T][T];
    logic valid_out, done_tile, out_shape_flag;

    logic signed [DW-1:0] exp_vec [T];
    logic signed [DW-1:0] exp_mat [T][T];

    int errors = 0;
    int checks = 0;

    // a[i][j] = a_c + a_s*i (or identity), b_vec[j] = b_c + b_s*j, b_mat = b_c.
    // Expected: vec[i] = e_c + e_s*i, or every mat element = e_c.
    typedef struct {
        logic [2:0] mode;
        bit         acc_en;
        int         a_c;
        int         a_s;
        bit         a_id;
        int         b_c;
        int         b_s;
        int         acc;
        bit         flag;
        int         e_c;
        int         e_s;
    } vec_t;

    vec_t tbl [NV];

    recfg_array #(
        .DATA_WIDTH (DW),
        .TILE_SIZE  (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .mode           (mode),
        .a_in           (a_in),
        .b_vec          (b_vec),
        .b_mat          (b_mat),
        .accumulate_en  (accumulate_en),
        .acc_in_vec     (acc_in_vec),
        .result_out_vec (result_out_vec),
        .result_out_mat (result_out_mat),
        .valid_out      (valid_out),
        .done_tile      (done_tile),
        .out_shape_flag (out_shape_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_data(input string tag);
        int bv = -1;
        int bi = -1;
        int bj = -1;
        for (int i = 0; i < T; i++) begin
            if (bv < 0 && result_out_vec[i] !== exp_vec[i]) bv = i;
            for (int j = 0; j < T; j++) begin
                if (bi < 0 && result_out_mat[i][j] !== exp_mat[i][j]) begin
                    bi = i;
                    bj = j;
                end
            end
        end
        checks++;
        if (bv >= 0) begin
            errors++;
            $display("FAIL %s vec[%0d]: got %0d expected %0d", tag, bv, result_out_vec[bv],
                     exp_vec[bv]);
        end
        checks++;
        if (bi >= 0) begin
            errors++;
            $display("FAIL %s mat[%0d][%0d]: got %0d expected %0d", tag, bi, bj,
                     result_out_mat[bi][bj], exp_mat[bi][bj]);
        end
    endtask

    task automatic load(input vec_t v);
        mode          = v.mode;
        accumulate_en = v.acc_en;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                a_in[i][j]  = v.a_id ? DW'(i == j) : DW'(v.a_c + v.a_s * i);
                b_mat[i][j] = DW'(v.b_c);
            end
            b_vec[i]      = DW'(v.b_c + v.b_s * i);
            acc_in_vec[i] = DW'(v.acc);
        end
    endtask

    task automatic expect_pulse(input vec_t v, input string tag);
        if (v.flag) begin
            for (int i = 0; i < T; i++) begin
                for (int j = 0; j < T; j++) exp_mat[i][j] = DW'(v.e_c);
            end
        end else begin
            for (int i = 0; i < T; i++) exp_vec[i] = DW'(v.e_c + v.e_s * i);
        end
        check_bit({tag, " valid_out"}, valid_out, 1'b1);
        check_bit({tag, " done_tile"}, done_tile, 1'b1);
        check_bit({tag, " shape_flag"}, out_shape_flag, v.flag);
        check_data(tag);
    endtask

    initial begin
        int    lat;
        int    seen;
        string tag;

        //         mode          acc a_c    a_s id b_c b_s acc  flg e_c     e_s
        tbl[0]  = '{MODE_EWA_VEC, 1'b0, -4,    1, 1'b0, 2,  0, 0,   1'b0, -2,     1};
        tbl[1]  = '{MODE_EWA_MAT, 1'b0, 3,     0, 1'b0, -4, 0, 0,   1'b1, -1,     0};
        tbl[2]  = '{MODE_EWM_MAT, 1'b0, -3,    0, 1'b0, 2,  0, 0,   1'b1, -6,     0};
        tbl[3]  = '{MODE_GEMV,    1'b1, 0,     0, 1'b1, 0,  1, 10,  1'b0, 10,     1};
        tbl[4]  = '{MODE_EWM_VEC, 1'b1, -4,    1, 1'b0, 3,  0, 5,   1'b0, -7,     3};
        tbl[5]  = '{MODE_GEMV,    1'b0, 0,     1, 1'b0, 0,  1, 0,   1'b0, 0,      120};
        tbl[6]  = '{3'b010,       1'b1, 3,     0, 1'b0, 2,  0, 10,  1'b0, 0,      0};
        tbl[7]  = '{MODE_EWA_VEC, 1'b1, -4,    1, 1'b0, 2,  0, -1,  1'b0, -3,     1};
        tbl[8]  = '{MODE_EWA_MAT, 1'b1, 3,     0, 1'b0, -4, 0, 100, 1'b1, -1,     0};
        tbl[9]  = '{MODE_EWM_MAT, 1'b0, 32767, 0, 1'b0, 2,  0, 0,   1'b1, -2,     0};
        tbl[10] = '{MODE_EWA_MAT, 1'b0, 32767, 0, 1'b0, 1,  0, 0,   1'b1, -32768, 0};
        tbl[11] = '{MODE_GEMV,    1'b1, 16384, 0, 1'b0, 1,  0, 5,   1'b0, 5,      0};
        tbl[12] = '{MODE_GEMV,    1'b0, -3,    1, 1'b0, -8, 1, 0,   1'b0, 24,     -8};
        tbl[13] = '{3'b111,       1'b1, 1,     0, 1'b0, 1,  0, 7,   1'b0, 0,      0};

        for (int i = 0; i < T; i++) begin
            exp_vec[i] = '0;
            for (int j = 0; j < T; j++) exp_mat[i][j] = '0;
        end
        load(tbl[0]);

        #3;
        check_bit("reset valid_out", valid_out, 1'b0);
        check_bit("reset done_tile", done_tile, 1'b0);
        check_bit("reset shape_flag", out_shape_flag, 1'b0);
        check_data("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            tag = $sformatf("vec%0d", k);
            @(negedge clk);
            load(tbl[k]);
            valid_in = 1'b1;
            @(negedge clk);
            valid_in = 1'b0;
            load(tbl[(k + 5) % NV]);
            lat = 1;
            while (valid_out !== 1'b1 && lat < 8) begin
                @(negedge clk);
                lat++;
            end
            check_int({tag, " latency"}, lat, 3);
            expect_pulse(tbl[k], tag);
            @(negedge clk);
            check_bit({tag, " pulse_end"}, valid_out, 1'b0);
        end

        // Back-to-back EWA-vec, EWA-mat, EWM-mat.
        @(negedge clk);
        load(tbl[0]);
        valid_in = 1'b1;
        @(negedge clk);
        load(tbl[1]);
        @(negedge clk);
        check_bit("b2b early", valid_out, 1'b0);
        load(tbl[2]);
        @(negedge clk);
        valid_in = 1'b0;
        load(tbl[12]);
        expect_pulse(tbl[0], "b2b0");
        @(negedge clk);
        expect_pulse(tbl[1], "b2b1");
        @(negedge clk);
        expect_pulse(tbl[2], "b2b2");
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_bit($sformatf("b2b idle%0d", n), valid_out, 1'b0);
        end
        check_data("b2b hold");

        // Reset one cycle after a transaction is accepted.
        @(negedge clk);
        load(tbl[4]);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = 0; i < T; i++) begin
            exp_vec[i] = '0;
            for (int j = 0; j < T; j++) exp_mat[i][j] = '0;
        end
        check_bit("rst_async valid_out", valid_out, 1'b0);
        check_bit("rst_async shape_flag", out_shape_flag, 1'b0);
        check_data("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (valid_out !== 1'b0 || done_tile !== 1'b0) seen++;
        end
        check_int("rst_discard pulses", seen, 0);
        check_bit("rst_discard shape_flag", out_shape_flag, 1'b0);
        check_data("rst_discard");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/recfg_array.md
RECFG_ARRAY -- requirements
Module: recfg_array

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed two's-complement width of every data element.
REQ-002 Parameter TILE_SIZE, default 16: tile dimension T; the array processes one T x T tile per transaction.
REQ-003 One clock; reset is asynchronous and active-low: clk input 1: rising-edge clock.
REQ-004 rst_n input 1: asynchronous active-low reset.
REQ-005 valid_in input 1: one-cycle strobe; all operand inputs and mode are sampled on a rising clk edge where valid_in=1.
REQ-006 mode input 3: operation select (see Function).
REQ-007 a_in input signed [DATA_WIDTH] array [T][T]: operand A.
REQ-008 b_vec input signed [DATA_WIDTH] array [T]: vector operand B.
REQ-009 b_mat input signed [DATA_WIDTH] array [T][T]: matrix operand B.
REQ-010 accumulate_en input 1: adds acc_in_vec to vector-shaped results.
REQ-011 acc_in_vec input signed [DATA_WIDTH] array [T]: accumulation operand.
REQ-012 result_out_vec output signed [DATA_WIDTH] array [T]: vector result.
REQ-013 result_out_mat output signed [DATA_WIDTH] array [T][T]: matrix result.
REQ-014 valid_out output 1: one-cycle pulse, results newly valid.
REQ-015 done_tile output 1: one-cycle pulse, coincident with valid_out.
REQ-016 out_shape_flag output 1: 0 = vector result, 1 = matrix result; valid with valid_out.

Function
REQ-017 mode 000 GEMV: vec[i] = sum over j of a_in[i][j]*b_vec[j].
REQ-018 mode 001 EWM-vector: vec[i] = a_in[i][0]*b_vec[i].
REQ-019 mode 100 EWA-vector: vec[i] = a_in[i][0] + b_vec[i].
REQ-020 mode 101 EWA-matrix: mat[i][j] = a_in[i][j] + b_mat[i][j].
REQ-021 mode 110 EWM-matrix: mat[i][j] = a_in[i][j]*b_mat[i][j].
REQ-022 modes 010, 011, 111 reserved: produce all-zero vec, out_shape_flag=0, handshake unchanged.
REQ-023 Vector modes (000, 001, 100) with accumulate_en=1 add acc_in_vec[i] to vec[i]; accumulate_en ignored in matrix modes.
REQ-024 Arithmetic is integer; products and sums are computed at full precision and the final result is truncated (wrap) to the low DATA_WIDTH bits; no saturation, no scaling.
REQ-025 Latency: valid_out, done_tile and out_shape_flag assert exactly 2 clk cycles after the sampling edge (sample edge N, pulse high after edge N+2).
REQ-026 Fully pipelined: a new valid_in is accepted every cycle; no backpressure; back-to-back transactions produce back-to-back pulses in order.
REQ-027 result_out_vec and result_out_mat update only with valid_out and hold their values until the next valid_out; the unused shape's output is left unchanged.
REQ-028 out_shape_flag = 1 for modes 101, 110; 0 otherwise.
REQ-029 Inputs when valid_in=0 have no effect.

Reset
REQ-030 rst_n low asynchronously clears valid_out, done_tile, out_shape_flag, all result elements and all pipeline valid bits to 0.
REQ-031 Transactions in flight at reset are discarded; no pulse emitted for them after rst_n releases.

Structure
REQ-032 Package recfg_array_pkg holds the mode encoding enum (MODE_GEMV, MODE_EWM_VEC, MODE_EWA_VEC, MODE_EWA_MAT, MODE_EWM_MAT) and default width constants.
REQ-033 One sub-module, recfg_pe: a single signed multiply/add cell selectable per mode, instantiated T x T; GEMV row reduction is an adder tree outside the PE.

Verification
REQ-034 mode 100, a_in[i][0]=i-4, b_vec[i]=2, accumulate_en=0 -> result_out_vec[i]=i-2, out_shape_flag=0, done_tile pulse 2 cycles after valid_in.
REQ-035 mode 101, a_in=all 3, b_mat=all -4 -> every result_out_mat element = -1, out_shape_flag=1.
REQ-036 mode 110, a_in[i][j]=-3, b_mat[i][j]=2 -> every element = -6; 0x7FFF*2 -> 0xFFFE (wrap).
REQ-037 mode 000, a_in=identity, b_vec[j]=j, accumulate_en=1, acc_in_vec=all 10 -> result_out_vec[i]=i+10.
REQ-038 Back-to-back: valid_in on 3 consecutive cycles with modes 100, 101, 110 -> 3 consecutive valid_out pulses, flags 0,1,1, correct results; results held stable afterwards.
REQ-039 Assert rst_n low one cycle after valid_in -> no valid_out ever appears for that transaction; all outputs 0.
